// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage that commits either an ALU result or
// a returning load value to the register file.
//
// Valid/ready: a result transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready is low only while a load is outstanding (WAIT_MEM), so
// in_valid may be held high across that period without losing the request.
//
// Each accepted instruction produces exactly one COMMIT cycle. During that
// cycle no_write reflects whether the register file should be written. The
// next result may be accepted in the same COMMIT cycle (back-to-back). If a
// load gets no mem_rvalid within MEM_TIMEOUT waiting cycles, the stage pulses
// mem_err and commits with the write suppressed.
//
// dst_reg and wb_data change only on a real commit (ALU accept or load data
// return). A timed-out load leaves them at their previous values.
//
// Optional feature: define WB_FORWARD_EN to add the fwd_valid/fwd_reg/fwd_data
// bypass outputs. These mirror the committing write in the same cycle.

module writeback_stage #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [1:0]            dst_reg_in,
  input  logic                  wb_sel,
  input  logic                  wr_en_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic [1:0]            dst_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  no_write,
  output logic                  mem_err,
  output logic [1:0]            fsm_state
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_valid,
  output logic [1:0]            fwd_reg,
  output logic [DATA_WIDTH-1:0] fwd_data
`endif
);

  // Counter wide enough to hold MEM_TIMEOUT itself.
  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_inc;
  logic [1:0]    pend_dst;  // destination of the outstanding load
  logic          pend_wr;   // write enable of the outstanding load
  logic          accept;

  assign accept       = in_valid & in_ready;
  assign wait_cnt_inc = wait_cnt + CW'(1);
  assign fsm_state    = state;

  // Stage FSM. All outputs are registered here, and capture registers hold
  // their values unless a transfer or load return happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      dst_reg  <= 2'd0;
      wb_data  <= '0;
      no_write <= 1'b1;
      mem_err  <= 1'b0;
      wait_cnt <= '0;
      pend_dst <= 2'd0;
      pend_wr  <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (accept && !wb_sel) begin
            // ALU result: commit on the very next cycle.
            state    <= COMMIT;
            in_ready <= 1'b1;
            dst_reg  <= dst_reg_in;
            wb_data  <= alu_result;
            no_write <= ~wr_en_in;
          end else if (accept && wb_sel) begin
            // Load: remember where it goes and wait for the data.
            state    <= WAIT_MEM;
            in_ready <= 1'b0;
            pend_dst <= dst_reg_in;
            pend_wr  <= wr_en_in;
            wait_cnt <= '0;
            no_write <= 1'b1;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
            no_write <= 1'b1;
          end
        end

        WAIT_MEM: begin
          if (mem_rvalid) begin
            state    <= COMMIT;
            in_ready <= 1'b1;
            dst_reg  <= pend_dst;
            wb_data  <= mem_rdata;
            no_write <= ~pend_wr;
          end else if (wait_cnt_inc == TO_LIMIT) begin
            // Load never arrived: flag it and retire without writing.
            state    <= COMMIT;
            in_ready <= 1'b1;
            mem_err  <= 1'b1;
            no_write <= 1'b1;
            wait_cnt <= wait_cnt_inc;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          no_write <= 1'b1;
        end
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  // Bypass view of the write happening this cycle.
  always_comb begin
    fwd_valid = ~no_write;
    fwd_reg   = dst_reg;
    fwd_data  = wb_data;
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed sequences plus a table of back-to-back ALU
// results. Each driven cycle pushes the outputs expected in the following
// cycle, and a negedge monitor pops and compares them.

module tb_writeback_stage;

  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_result;
  logic [1:0]    dst_reg_in;
  logic          wb_sel;
  logic          wr_en_in;
  logic [DW-1:0] mem_rdata;
  logic          mem_rvalid;
  logic [1:0]    dst_reg;
  logic [DW-1:0] wb_data;
  logic          no_write;
  logic          mem_err;
  logic [1:0]    fsm_state;
`ifdef WB_FORWARD_EN
  logic          fwd_valid;
  logic [1:0]    fwd_reg;
  logic [DW-1:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  // Expected outputs packed as {in_ready, no_write, mem_err, dst_reg, wb_data}.
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;

  typedef struct {
    logic [7:0] alu;
    logic [1:0] dst;
    logic       wr;
    logic       exp_nw;
  } vec_t;

  vec_t tbl[8];

  writeback_stage #(.DATA_WIDTH(DW), .MEM_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_result (alu_result),
    .dst_reg_in (dst_reg_in),
    .wb_sel     (wb_sel),
    .wr_en_in   (wr_en_in),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .dst_reg    (dst_reg),
    .wb_data    (wb_data),
    .no_write   (no_write),
    .mem_err    (mem_err),
    .fsm_state  (fsm_state)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid  (fwd_valid),
    .fwd_reg    (fwd_reg),
    .fwd_data   (fwd_data)
`endif
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [12:0] mk(input logic rdy, input logic nw, input logic err,
                                     input logic [1:0] d, input logic [7:0] v);
    return {rdy, nw, err, d, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("in_ready", 32'(in_ready), 32'(mon_e[12]));
      check("no_write", 32'(no_write), 32'(mon_e[11]));
      check("mem_err",  32'(mem_err),  32'(mon_e[10]));
      check("dst_reg",  32'(dst_reg),  32'(mon_e[9:8]));
      check("wb_data",  32'(wb_data),  32'(mon_e[7:0]));
`ifdef WB_FORWARD_EN
      check("fwd_valid", 32'(fwd_valid), 32'(~mon_e[11]));
      check("fwd_reg",   32'(fwd_reg),   32'(mon_e[9:8]));
      check("fwd_data",  32'(fwd_data),  32'(mon_e[7:0]));
`endif
    end
  end

  // Driver: apply inputs for one cycle, then record what the next cycle must show.
  task automatic cyc(input logic v, input logic [7:0] alu, input logic [1:0] d,
                     input logic sel, input logic wr, input logic rv,
                     input logic [7:0] rd, input logic [12:0] e);
    in_valid   = v;
    alu_result = alu;
    dst_reg_in = d;
    wb_sel     = sel;
    wr_en_in   = wr;
    mem_rvalid = rv;
    mem_rdata  = rd;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input logic [12:0] e);
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},    32'(fsm_state), 32'(0));
    check({tag, "_dst_reg"},  32'(dst_reg),   32'(0));
    check({tag, "_wb_data"},  32'(wb_data),   32'(0));
    check({tag, "_no_write"}, 32'(no_write),  32'(1));
    check({tag, "_mem_err"},  32'(mem_err),   32'(0));
    check({tag, "_in_ready"}, 32'(in_ready),  32'(1));
  endtask

  initial begin
    // Vector table: the fixed back-to-back sequence, a no-write entry, then random ones.
    tbl[0] = '{8'h01, 2'd0, 1'b1, 1'b0};
    tbl[1] = '{8'h02, 2'd1, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 2'd3, 1'b1, 1'b0};
    tbl[3] = '{8'h77, 2'd2, 1'b0, 1'b1};
    for (int i = 4; i < 8; i++) begin
      tbl[i].alu    = 8'($urandom_range(0, 255));
      tbl[i].dst    = 2'($urandom_range(0, 3));
      tbl[i].wr     = 1'($urandom_range(0, 1));
      tbl[i].exp_nw = ~tbl[i].wr;
    end

    // Reset.
    rst        = 1'b0;
    in_valid   = 1'b0;
    alu_result = '0;
    dst_reg_in = '0;
    wb_sel     = 1'b0;
    wr_en_in   = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle, and mem_rvalid outside WAIT_MEM is ignored.
    idle(mk(1'b1, 1'b1, 1'b0, 2'd0, 8'h00));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'hEE, mk(1'b1, 1'b1, 1'b0, 2'd0, 8'h00));

    // Single ALU write: commit for exactly one cycle.
    cyc(1'b1, 8'h5A, 2'd2, 1'b0, 1'b1, 1'b0, 8'h00, mk(1'b1, 1'b0, 1'b0, 2'd2, 8'h5A));
    idle(mk(1'b1, 1'b1, 1'b0, 2'd2, 8'h5A));

    // Load to r1; requests offered while waiting are refused; data three cycles later.
    cyc(1'b1, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 8'h00, mk(1'b0, 1'b1, 1'b0, 2'd2, 8'h5A));
    cyc(1'b1, 8'h99, 2'd3, 1'b0, 1'b1, 1'b0, 8'h00, mk(1'b0, 1'b1, 1'b0, 2'd2, 8'h5A));
    cyc(1'b1, 8'h99, 2'd3, 1'b0, 1'b1, 1'b0, 8'h00, mk(1'b0, 1'b1, 1'b0, 2'd2, 8'h5A));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'hC3, mk(1'b1, 1'b0, 1'b0, 2'd1, 8'hC3));
    idle(mk(1'b1, 1'b1, 1'b0, 2'd1, 8'hC3));

    // Load that never returns: 15 waiting cycles, then the error pulse.
    cyc(1'b1, 8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 8'h00, mk(1'b0, 1'b1, 1'b0, 2'd1, 8'hC3));
    for (int k = 1; k < TO; k++) begin
      idle(mk(1'b0, 1'b1, 1'b0, 2'd1, 8'hC3));
    end
    idle(mk(1'b1, 1'b1, 1'b1, 2'd1, 8'hC3));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'hEE, mk(1'b1, 1'b1, 1'b0, 2'd1, 8'hC3));
    idle(mk(1'b1, 1'b1, 1'b0, 2'd1, 8'hC3));

    // Back-to-back ALU results from the table; in_ready must stay 1 throughout.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, tbl[i].alu, tbl[i].dst, 1'b0, tbl[i].wr, 1'b0, 8'h00,
          mk(1'b1, tbl[i].exp_nw, 1'b0, tbl[i].dst, tbl[i].alu));
    end

    // Load accepted in a COMMIT cycle, with wr_en_in=0: commit with no write.
    cyc(1'b1, 8'h00, 2'd2, 1'b1, 1'b0, 1'b0, 8'h00, mk(1'b0, 1'b1, 1'b0, tbl[7].dst, tbl[7].alu));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'h3C, mk(1'b1, 1'b1, 1'b0, 2'd2, 8'h3C));
    idle(mk(1'b1, 1'b1, 1'b0, 2'd2, 8'h3C));

    // Reset while a load is outstanding, with data arriving around the reset.
    cyc(1'b1, 8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 8'h00, mk(1'b0, 1'b1, 1'b0, 2'd2, 8'h3C));
    @(negedge clk);
    #1;
    rst        = 1'b0;
    in_valid   = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 8'hAA;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'hAA, mk(1'b1, 1'b1, 1'b0, 2'd0, 8'h00));
    cyc(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b1, 8'hAA, mk(1'b1, 1'b1, 1'b0, 2'd0, 8'h00));
    idle(mk(1'b1, 1'b1, 1'b0, 2'd0, 8'h00));

    // Drain the scoreboard.
    @(negedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of result and write-back data.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum cycles spent waiting for load data.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  upstream result valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-008 SHALL have port alu_result  input  DATA_WIDTH  ALU result.
REQ-009 SHALL have port dst_reg_in  input  2  destination register index.
REQ-010 SHALL have port wb_sel  input  1  0 = write ALU result, 1 = write load data.
REQ-011 SHALL have port wr_en_in  input  1  instruction writes a register.
REQ-012 SHALL have port mem_rdata  input  DATA_WIDTH  load data.
REQ-013 SHALL have port mem_rvalid  input  1  load data valid.
REQ-014 SHALL have port dst_reg  output  2  register-file write index.
REQ-015 SHALL have port wb_data  output  DATA_WIDTH  register-file write data.
REQ-016 SHALL have port no_write  output  1  1 = suppress register-file write.
REQ-017 SHALL have port mem_err  output  1  one-cycle pulse on load timeout.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_MEM and COMMIT.
REQ-019 SHALL accept a result only on a cycle where in_valid and in_ready are both 1.
REQ-020 SHALL drive in_ready high in IDLE and COMMIT, and low in WAIT_MEM.
REQ-021 SHALL go to COMMIT on an accepted wb_sel=0 result, capturing alu_result, dst_reg_in and wr_en_in.
REQ-022 SHALL go to WAIT_MEM on an accepted wb_sel=1 result, capturing dst_reg_in and wr_en_in and clearing the timeout counter.
REQ-023 SHALL sample mem_rvalid in WAIT_MEM only; mem_rvalid in IDLE or COMMIT is ignored.
REQ-024 SHALL, in WAIT_MEM with mem_rvalid=1, capture mem_rdata and go to COMMIT.
REQ-025 SHALL, in WAIT_MEM, increment the timeout counter each cycle without mem_rvalid.
REQ-026 SHALL, when the timeout counter reaches MEM_TIMEOUT, pulse mem_err for one cycle and go to COMMIT with the write suppressed.
REQ-027 SHALL, in COMMIT, drive no_write = NOT captured wr_en_in (forced to 1 after a timeout), for exactly one cycle.
REQ-028 SHALL drive dst_reg and wb_data from registers in all states.
REQ-029 SHALL drive no_write=1 in IDLE and WAIT_MEM.
REQ-030 SHALL make an ALU result accepted in cycle N drive no_write=0 in cycle N+1 only.
REQ-031 SHALL make a load whose mem_rvalid is sampled in cycle M commit in cycle M+1.
REQ-032 SHALL, in COMMIT, accept a new result in the same cycle (back-to-back) and take the REQ-021/REQ-022 transition; otherwise it returns to IDLE.
REQ-033 SHALL hold the capture registers unchanged while no transfer occurs.

Reset
REQ-034 SHALL, on rst low, immediately enter IDLE with dst_reg=0, wb_data=0, no_write=1, mem_err=0, in_ready=1 and timeout counter=0.
REQ-035 SHALL, on reset during WAIT_MEM or COMMIT, discard the pending result with no register write.

Configuration
REQ-036 SHALL support macro WB_FORWARD_EN.
REQ-037 SHALL, with WB_FORWARD_EN defined, add outputs fwd_valid (1), fwd_reg (2) and fwd_data (DATA_WIDTH), equal to NOT no_write, dst_reg and wb_data in the same cycle; fwd_valid resets to 0.
REQ-038 SHALL, without WB_FORWARD_EN, have no forwarding ports or logic.

Verification
REQ-039 SHALL verify: ALU result 0x5A, dst_reg_in=2, wr_en_in=1 accepted in cycle 3 -> cycle 4 shows dst_reg=2, wb_data=0x5A, no_write=0; cycle 5 shows no_write=1.
REQ-040 SHALL verify: load to r1 accepted, mem_rvalid with mem_rdata=0xC3 three cycles later -> in_ready=0 while waiting, commit of 0xC3 to r1 one cycle after mem_rvalid.
REQ-041 SHALL verify: load accepted with mem_rvalid never asserted -> mem_err pulses one cycle after 15 waiting cycles, no_write stays 1, in_ready returns to 1.
REQ-042 SHALL verify: three back-to-back ALU results (r0=0x01, r1=0x02, r3=0xFF) -> three consecutive commit cycles, in_ready constantly 1.
REQ-043 SHALL verify: wr_en_in=0 result accepted -> COMMIT cycle with no_write=1.
REQ-044 SHALL verify: rst asserted during WAIT_MEM, then mem_rvalid -> outputs at reset values immediately, and no write occurs.
